// File: rtl/regb_fifo_chain.sv
// Register-chain FIFO: DEPTH stages with per-stage valid bits and stage 0 as the head.
// Data falls through to the lowest free stage; sticky overflow/underflow flags are cleared by clr_err.
module regb_fifo_chain #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       res_n,
  input  logic [WIDTH-1:0]           si,
  input  logic                       shift_in,
  input  logic                       shift_out,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           so,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] data_d  [DEPTH];
  logic [WIDTH-1:0] data_sh [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d, valid_sh;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             pop_acc, push_acc, placed;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_empty = (32'(count_q) <= AE_LEVEL);
  assign almost_full  = (32'(count_q) >= AF_LEVEL);
  assign count        = count_q;
  assign so           = data_q[0];
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    pop_acc  = shift_out & ~empty;
    push_acc = shift_in & (~full | pop_acc);

    data_sh  = data_q;
    valid_sh = valid_q;
    if (pop_acc) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        data_sh[i] = data_q[i+1];
      end
      data_sh[DEPTH-1] = '0;
      valid_sh         = {1'b0, valid_q[DEPTH-1:1]};
    end

    // Valid stages are contiguous, so the first invalid stage after the shift is the tail.
    data_d  = data_sh;
    valid_d = valid_sh;
    placed  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (push_acc && !placed && !valid_sh[i]) begin
        data_d[i]  = si;
        valid_d[i] = 1'b1;
        placed     = 1'b1;
      end
    end

    count_d = count_q + CW'(push_acc) - CW'(pop_acc);

    // clr_err wins over an error raised in the same cycle.
    overflow_d  = clr_err ? 1'b0 : (overflow_q | (shift_in & full & ~shift_out));
    underflow_d = clr_err ? 1'b0 : (underflow_q | (shift_out & empty));
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      data_q      <= '{default: '0};
      valid_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_regb_fifo_chain.sv
// Directed bench for regb_fifo_chain (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1).
module tb_regb_fifo_chain;

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] si;
  logic       shift_in, shift_out, clr_err;
  logic [7:0] so;
  logic       empty, full, almost_empty, almost_full;
  logic [2:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  regb_fifo_chain #(
    .WIDTH   (8),
    .DEPTH   (4),
    .AF_LEVEL(3),
    .AE_LEVEL(1)
  ) dut (
    .clk         (clk),
    .res_n       (res_n),
    .si          (si),
    .shift_in    (shift_in),
    .shift_out   (shift_out),
    .clr_err     (clr_err),
    .so          (so),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic rn, input logic push, input logic pop, input logic [7:0] d,
                      input logic clr);
    res_n = rn; shift_in = push; shift_out = pop; si = d; clr_err = clr;
    @(posedge clk);
    #1;
    res_n = 1'b1; shift_in = 1'b0; shift_out = 1'b0; si = 8'h00; clr_err = 1'b0;
  endtask

  // Checks every output against the expected state.
  task automatic chk_all(input string tag, input int e_so, input int e_cnt, input int e_ov,
                         input int e_un);
    chk({tag, ".so"}, int'(so), e_so);
    chk({tag, ".count"}, int'(count), e_cnt);
    chk({tag, ".empty"}, int'(empty), int'(e_cnt == 0));
    chk({tag, ".full"}, int'(full), int'(e_cnt == 4));
    chk({tag, ".ae"}, int'(almost_empty), int'(e_cnt <= 1));
    chk({tag, ".af"}, int'(almost_full), int'(e_cnt >= 3));
    chk({tag, ".ov"}, int'(overflow), e_ov);
    chk({tag, ".un"}, int'(underflow), e_un);
  endtask

  initial begin
    res_n = 1'b0; shift_in = 1'b0; shift_out = 1'b0; si = 8'h00; clr_err = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_all("reset", 0, 0, 0, 0);

    // Fall-through and fill
    step(1'b1, 1'b1, 1'b0, 8'h11, 1'b0); chk_all("push1", 8'h11, 1, 0, 0);
    step(1'b1, 1'b1, 1'b0, 8'h22, 1'b0); chk_all("push2", 8'h11, 2, 0, 0);
    step(1'b1, 1'b1, 1'b0, 8'h33, 1'b0); chk_all("push3", 8'h11, 3, 0, 0);
    step(1'b1, 1'b1, 1'b0, 8'h44, 1'b0); chk_all("push4", 8'h11, 4, 0, 0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); chk_all("pop1", 8'h22, 3, 0, 0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); chk_all("pop2", 8'h33, 2, 0, 0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); chk_all("pop3", 8'h44, 1, 0, 0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); chk_all("pop4", 0, 0, 0, 0);

    // Simultaneous push/pop while full
    step(1'b1, 1'b1, 1'b0, 8'h11, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h22, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h44, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h55, 1'b0); chk_all("pp_full", 8'h22, 4, 0, 0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); chk_all("pp_pop1", 8'h33, 3, 0, 0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); chk_all("pp_pop2", 8'h44, 2, 0, 0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); chk_all("pp_pop3", 8'h55, 1, 0, 0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); chk_all("pp_pop4", 0, 0, 0, 0);

    // Overflow, sticky, clear, clear priority
    step(1'b1, 1'b1, 1'b0, 8'h11, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h22, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h44, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h66, 1'b0); chk_all("ovf", 8'h11, 4, 1, 0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); chk_all("ovf_sticky", 8'h11, 4, 1, 0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1); chk_all("ovf_clr", 8'h11, 4, 0, 0);
    step(1'b1, 1'b1, 1'b0, 8'h77, 1'b1); chk_all("ovf_clr_prio", 8'h11, 4, 0, 0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); chk_all("ovf_pop1", 8'h22, 3, 0, 0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); chk_all("ovf_pop2", 8'h33, 2, 0, 0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); chk_all("ovf_pop3", 8'h44, 1, 0, 0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); chk_all("ovf_pop4", 0, 0, 0, 0);

    // Underflow with concurrent push
    step(1'b1, 1'b1, 1'b1, 8'h77, 1'b0); chk_all("unf", 8'h77, 1, 0, 1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); chk_all("unf_sticky", 8'h77, 1, 0, 1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1); chk_all("unf_clr", 8'h77, 1, 0, 0);

    // Reset overrides a push mid-stream
    step(1'b1, 1'b1, 1'b0, 8'h88, 1'b0); chk_all("pre_rst", 8'h77, 2, 0, 0);
    step(1'b0, 1'b1, 1'b0, 8'h99, 1'b0); chk_all("rst_push", 0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 8'hAB, 1'b0); chk_all("post_rst", 8'hAB, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
